// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requests feeding a small in-order buffer.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misalign
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_addr;
    logic            inflight;
    logic            halted;

    logic [XLEN-1:0] buf_data [DEPTH];
    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   occupancy;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign fetch_misalign  = halted;
`else
    assign redirect_bad    = 1'b0;
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign fetch_misalign  = 1'b0;
`endif

    // The outstanding request reserves a slot so a full buffer can never be overrun.
    assign occupancy = count + CW'(inflight);
    assign issue     = !reset && !redirect_valid && !halted && (occupancy < DEPTH_C);
    assign push      = inflight && imem_rsp_valid && !redirect_valid;
    assign pop       = (count != '0) && instr_ready && !redirect_valid;

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc;
    assign instr_valid    = (count != '0);
    assign instr          = buf_data[head];
    assign instr_pc       = buf_pc[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VEC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            halted        <= 1'b0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
                pc            <= pc + XLEN'(4);
            end
            if (redirect_valid) begin
                pc     <= redirect_target;
                halted <= redirect_bad;
                head   <= '0;
                tail   <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    buf_data[tail] <= imem_rsp_data;
                    buf_pc[tail]   <= inflight_addr;
                    tail           <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic checked against a queue-based model.
module tb_fetch_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    fetch_stage #(.XLEN(32), .RESET_VEC(RVEC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected buffer contents as a queue of fetch addresses.
    logic [31:0] q[$];
    logic [31:0] m_pc;
    logic        m_infl;
    logic [31:0] m_infl_addr;
    logic        m_halt;
    logic        just_reset;

    // Memory: answers whatever the DUT actually requested last cycle.
    logic        mem_pend;
    logic [31:0] mem_addr;
    logic        spurious;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy, input logic rst);
        logic        exp_issue;
        logic        rsp;
        logic        bad;
        logic        s_req;
        logic [31:0] s_addr;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        rsp            = mem_pend | spurious;
        imem_rsp_valid = rsp;
        imem_rsp_data  = mem_word(mem_addr);
        spurious       = 1'b0;
        #2;
        exp_issue = !rst && !rv && !m_halt && ((q.size() + int'(m_infl)) < DEPTH);

        n_vec++;
        assert (imem_req_valid === exp_issue) else begin
            n_err++;
            $error("FAIL req_valid observed=%0b expected=%0b t=%0t", imem_req_valid, exp_issue, $time);
        end
        if (exp_issue) begin
            n_vec++;
            assert (imem_req_addr === m_pc) else begin
                n_err++;
                $error("FAIL req_addr observed=%h expected=%h t=%0t", imem_req_addr, m_pc, $time);
            end
        end
        n_vec++;
        assert (instr_valid === (q.size() != 0)) else begin
            n_err++;
            $error("FAIL instr_valid observed=%0b expected=%0b t=%0t", instr_valid, q.size() != 0, $time);
        end
        if (q.size() != 0) begin
            n_vec++;
            assert (instr_pc === q[0]) else begin
                n_err++;
                $error("FAIL instr_pc observed=%h expected=%h t=%0t", instr_pc, q[0], $time);
            end
            n_vec++;
            assert (instr === mem_word(q[0])) else begin
                n_err++;
                $error("FAIL instr observed=%h expected=%h t=%0t", instr, mem_word(q[0]), $time);
            end
        end
        if (just_reset) begin
            n_vec++;
            assert (instr === 32'h0 && instr_pc === 32'h0) else begin
                n_err++;
                $error("FAIL reset_instr observed=%h/%h expected=0/0 t=%0t", instr, instr_pc, $time);
            end
        end
        n_vec++;
        assert (fetch_misalign === m_halt) else begin
            n_err++;
            $error("FAIL misalign observed=%0b expected=%0b t=%0t", fetch_misalign, m_halt, $time);
        end

        s_req  = imem_req_valid;
        s_addr = imem_req_addr;
        @(posedge clk);

        just_reset = 1'b0;
        if (rst) begin
            q.delete();
            m_pc       = RVEC;
            m_infl     = 1'b0;
            m_halt     = 1'b0;
            just_reset = 1'b1;
        end else if (rv) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            bad  = (rpc[1:0] != 2'b00);
            m_pc = rpc;
`else
            bad  = 1'b0;
            m_pc = {rpc[31:2], 2'b00};
`endif
            q.delete();
            m_infl = 1'b0;
            m_halt = bad;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (m_infl && rsp) q.push_back(m_infl_addr);
            m_infl = exp_issue;
            if (exp_issue) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
        mem_pend = s_req;
        mem_addr = s_addr;
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        instr_ready    = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_pend = 1'b0; mem_addr = '0; spurious = 1'b0;
        m_pc = RVEC; m_infl = 1'b0; m_infl_addr = '0; m_halt = 1'b0; just_reset = 1'b0;
        @(posedge clk);
        #1;
        // reset overrides redirect
        cycle(1'b1, 32'h0000_0040, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0080, 1'b1, 1'b1);
        // stray response in first post-reset cycle must be dropped
        spurious = 1'b1;
        run(12, 1'b1);
        // back-pressure: four requests then stall, then resume
        run(8, 1'b0);
        run(6, 1'b1);
        // redirect while a response is arriving
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0);
        run(6, 1'b1);
        // full buffer, then simultaneous pop and response
        run(7, 1'b0);
        run(8, 1'b1);
        // address wrap
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        run(6, 1'b1);
        // misaligned target, then an aligned one
        cycle(1'b1, 32'h0000_0102, 1'b1, 1'b0);
        run(4, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0);
        run(5, 1'b1);
        // back-to-back redirects, last one wins
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0400, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0500, 1'b1, 1'b0);
        run(5, 1'b1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 199) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
